dt_skeleton_pack: RTL and testbench

// - Downstream stage of the distance-transform engine. After DT asserts done, this block scans the
//   128x128 8-bit distance map in res RAM and marks local maxima (medial-axis skeleton).
// - Packs the skeleton 16 px/word, MSB = leftmost pixel (same layout as sti ROM), into a 1024x16 skl RAM.
// - Also reports the max distance and the skeleton pixel count.

---
 rtl/dt_skeleton_pack.sv | 207 ++++++++++++++++++++
 tb/tb_dt_skeleton_pack.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_skeleton_pack.sv
// dt_skeleton_pack
// Scans the IMG_W x IMG_W 8-bit distance map held in res RAM after the
// distance transform finishes. A pixel is marked as a skeleton pixel when it is
// nonzero and no neighbour is larger; ties still count as maxima. Marked pixels
// are packed 16 per word, MSB = leftmost pixel, into skl RAM. The block also
// reports the largest distance seen and the number of skeleton pixels.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low
//   start     1-cycle pulse; ignored while busy
//   res_rd    res RAM read enable
//   res_addr  res RAM address (row*IMG_W + col)
//   res_di    res RAM data, valid the cycle after the read is presented
//   skl_wr    skl RAM write strobe (1-cycle pulse)
//   skl_addr  skl word address (pixel_index >> 4)
//   skl_do    packed skeleton word, bit 15-(col%16) = pixel
//   busy      high from the cycle after an accepted start until done
//   done      sticky high after the final skl write, cleared by the next start
//   max_dist  largest distance value seen (valid when done)
//   pix_cnt   number of skeleton pixels (valid when done)
//
// Configuration macro
//   DT_SKEL_8N_EN  when defined, the four diagonal neighbours are tested too
//                  (8-neighbour); otherwise only N, W, E, S are tested.

module dt_skeleton_pack #(
   parameter int IMG_W = 128,
   parameter int AW    = 14,
   parameter int SAW   = 10
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   output logic           res_rd,
   output logic [AW-1:0]  res_addr,
   input  logic [7:0]     res_di,
   output logic           skl_wr,
   output logic [SAW-1:0] skl_addr,
   output logic [15:0]    skl_do,
   output logic           busy,
   output logic           done,
   output logic [7:0]     max_dist,
   output logic [14:0]    pix_cnt
);

   localparam int LW = AW / 2;
   localparam logic [LW-1:0] EDGE = LW'(IMG_W - 1);
   localparam logic [AW-1:0] ROW  = AW'(IMG_W);
   localparam logic [AW-1:0] ONE  = AW'(1);

`ifdef DT_SKEL_8N_EN
   typedef enum logic [3:0] {
      IDLE, RD_C, RD_N, RD_W, RD_E, RD_S, RD_NW, RD_NE, RD_SW, RD_SE, CMP, PACK, DONE
   } state_t;
`else
   typedef enum logic [3:0] {
      IDLE, RD_C, RD_N, RD_W, RD_E, RD_S, CMP, PACK, DONE
   } state_t;
`endif

   state_t          state, state_nxt;
   logic [AW-1:0]   pix_index, pix_nxt;
   logic            rd_nxt;
   logic [AW-1:0]   addr_nxt;
   logic            rd_q;
   logic [7:0]      cap;
   logic [7:0]      c_val;
   logic            ok;
   logic [15:0]     shreg;
   logic [LW-1:0]   row_n, col_n;
   logic            top_n, bot_n, lft_n, rgt_n;

   // A read that was suppressed because the neighbour lies outside the image
   // returns 0, which can never beat a nonzero centre.
   assign cap = rd_q ? res_di : 8'h00;

   assign row_n = pix_nxt[AW-1:LW];
   assign col_n = pix_nxt[LW-1:0];
   assign top_n = (row_n == '0);
   assign bot_n = (row_n == EDGE);
   assign lft_n = (col_n == '0);
   assign rgt_n = (col_n == EDGE);

   // Next-state and next pixel index.
   always_comb begin
      state_nxt = state;
      pix_nxt   = pix_index;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RD_C;
               pix_nxt   = '0;
            end
         end
         RD_C:  state_nxt = RD_N;
         RD_N:  state_nxt = (cap == 8'h00) ? PACK : RD_W;
         RD_W:  state_nxt = RD_E;
         RD_E:  state_nxt = RD_S;
`ifdef DT_SKEL_8N_EN
         RD_S:  state_nxt = RD_NW;
         RD_NW: state_nxt = RD_NE;
         RD_NE: state_nxt = RD_SW;
         RD_SW: state_nxt = RD_SE;
         RD_SE: state_nxt = CMP;
`else
         RD_S:  state_nxt = CMP;
`endif
         CMP:   state_nxt = PACK;
         PACK: begin
            pix_nxt   = pix_index + ONE;
            state_nxt = (&pix_index) ? DONE : RD_C;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read request for the state being entered, so the registered res_rd and
   // res_addr line up with the RD_x state itself.
   always_comb begin
      rd_nxt   = 1'b0;
      addr_nxt = '0;
      case (state_nxt)
         RD_C:  begin rd_nxt = 1'b1;             addr_nxt = pix_nxt;             end
         RD_N:  begin rd_nxt = !top_n;           addr_nxt = pix_nxt - ROW;       end
         RD_W:  begin rd_nxt = !lft_n;           addr_nxt = pix_nxt - ONE;       end
         RD_E:  begin rd_nxt = !rgt_n;           addr_nxt = pix_nxt + ONE;       end
         RD_S:  begin rd_nxt = !bot_n;           addr_nxt = pix_nxt + ROW;       end
`ifdef DT_SKEL_8N_EN
         RD_NW: begin rd_nxt = !top_n && !lft_n; addr_nxt = pix_nxt - ROW - ONE; end
         RD_NE: begin rd_nxt = !top_n && !rgt_n; addr_nxt = pix_nxt - ROW + ONE; end
         RD_SW: begin rd_nxt = !bot_n && !lft_n; addr_nxt = pix_nxt + ROW - ONE; end
         RD_SE: begin rd_nxt = !bot_n && !rgt_n; addr_nxt = pix_nxt + ROW + ONE; end
`endif
         default: begin rd_nxt = 1'b0; addr_nxt = '0; end
      endcase
   end

   // State, datapath and registered outputs. Each state captures the data
   // requested by the previous state; ok accumulates "centre >= neighbour".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         pix_index <= '0;
         res_rd    <= 1'b0;
         res_addr  <= '0;
         rd_q      <= 1'b0;
         c_val     <= 8'h00;
         ok        <= 1'b0;
         shreg     <= 16'h0000;
         skl_wr    <= 1'b0;
         skl_addr  <= '0;
         skl_do    <= 16'h0000;
         busy      <= 1'b0;
         done      <= 1'b0;
         max_dist  <= 8'h00;
         pix_cnt   <= 15'd0;
      end else begin
         state     <= state_nxt;
         pix_index <= pix_nxt;
         res_rd    <= rd_nxt;
         res_addr  <= rd_nxt ? addr_nxt : '0;
         rd_q      <= res_rd;
         skl_wr    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  max_dist <= 8'h00;
                  pix_cnt  <= 15'd0;
                  shreg    <= 16'h0000;
               end
            end
            RD_N: begin
               c_val <= cap;
               ok    <= (cap != 8'h00);
               if (cap > max_dist) max_dist <= cap;
            end
`ifdef DT_SKEL_8N_EN
            RD_W, RD_E, RD_S, RD_NW, RD_NE, RD_SW, RD_SE, CMP: ok <= ok && (cap <= c_val);
`else
            RD_W, RD_E, RD_S, CMP: ok <= ok && (cap <= c_val);
`endif
            PACK: begin
               pix_cnt <= pix_cnt + {14'd0, ok};
               // The 16th pixel of a word completes it; write it out next cycle.
               if (pix_index[3:0] == 4'hF) begin
                  skl_wr   <= 1'b1;
                  skl_addr <= pix_index[AW-1:4];
                  skl_do   <= {shreg[14:0], ok};
                  shreg    <= 16'h0000;
               end else begin
                  shreg <= {shreg[14:0], ok};
               end
            end
            DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dt_skeleton_pack.sv
// tb_dt_skeleton_pack
// Self-checking bench for dt_skeleton_pack on a 32x32 image. Directed maps are
// listed in a vector table with hand-computed counts, maxima and one packed
// word each; a reference model of the skeleton rule supplies the full expected
// word map and read count. Hand-written sequences cover restart while done,
// start while busy and reset in mid-scan.

module tb_dt_skeleton_pack;

   localparam int IMG_W = 32;
   localparam int AW    = 10;
   localparam int SAW   = 6;
   localparam int NPIX  = IMG_W * IMG_W;
   localparam int NWORD = NPIX / 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           res_rd;
   logic [AW-1:0]  res_addr;
   logic [7:0]     res_di = 8'h00;
   logic           skl_wr;
   logic [SAW-1:0] skl_addr;
   logic [15:0]    skl_do;
   logic           busy;
   logic           done;
   logic [7:0]     max_dist;
   logic [14:0]    pix_cnt;

   always #5 clk = ~clk;

   dt_skeleton_pack #(.IMG_W(IMG_W), .AW(AW), .SAW(SAW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .res_rd   (res_rd),
      .res_addr (res_addr),
      .res_di   (res_di),
      .skl_wr   (skl_wr),
      .skl_addr (skl_addr),
      .skl_do   (skl_do),
      .busy     (busy),
      .done     (done),
      .max_dist (max_dist),
      .pix_cnt  (pix_cnt)
   );

   logic [7:0] mem [0:NPIX-1];

   always @(posedge clk) begin
      if (res_rd === 1'b1) res_di <= mem[res_addr];
   end

   typedef struct {
      int scen;
      int exp_cnt;
      int exp_max;
      int word_addr;
      int word_val;
   } vec_t;

   vec_t vecs [5];

   int total = 0;
   int bad   = 0;

   logic [15:0] wr_log     [0:NWORD-1];
   logic [15:0] gold_words [0:NWORD-1];
   int wr_cnt, order_err, rd_cnt;
   int gold_reads;

   // Write/read monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (skl_wr === 1'b1) begin
            if (int'(skl_addr) != wr_cnt) order_err++;
            wr_log[skl_addr] = skl_do;
            wr_cnt++;
         end
         if (res_rd === 1'b1) rd_cnt++;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic loadMap(input int scen);
      for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;
      case (scen)
         1: mem[16*IMG_W + 16] = 8'd1;
         2: begin
            for (int r = 10; r <= 12; r++)
               for (int c = 20; c <= 22; c++) mem[r*IMG_W + c] = 8'd1;
            mem[11*IMG_W + 21] = 8'd2;
         end
         3: mem[IMG_W - 1] = 8'hFF;
         4: begin
            for (int r = 4; r <= 6; r++)
               for (int c = 4; c <= 9; c++) mem[r*IMG_W + c] = 8'd3;
            mem[5*IMG_W + 7] = 8'd5;
         end
         default: ;
      endcase
   endtask

   // Reference: skeleton words by brute force over the neighbourhood, and the
   // number of reads (centre, N always issued, others only for nonzero centres).
   task automatic computeGold();
      gold_reads = 0;
      for (int w = 0; w < NWORD; w++) gold_words[w] = 16'h0000;
      for (int r = 0; r < IMG_W; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            int v;
            bit is_max;
            v = int'(mem[r*IMG_W + c]);
            gold_reads += 1 + ((r != 0) ? 1 : 0);
            is_max = (v != 0);
            if (v != 0) begin
               for (int dr = -1; dr <= 1; dr++) begin
                  for (int dc = -1; dc <= 1; dc++) begin
                     int rr, cc;
                     bit used;
                     used = !(dr == 0 && dc == 0);
`ifndef DT_SKEL_8N_EN
                     if (dr != 0 && dc != 0) used = 1'b0;
`endif
                     rr = r + dr;
                     cc = c + dc;
                     if (used && rr >= 0 && rr < IMG_W && cc >= 0 && cc < IMG_W) begin
                        if (!(dr == -1 && dc == 0)) gold_reads++;
                        if (int'(mem[rr*IMG_W + cc]) > v) is_max = 1'b0;
                     end
                  end
               end
            end
            if (is_max) gold_words[(r*IMG_W + c) / 16][15 - (c % 16)] = 1'b1;
         end
      end
   endtask

   task automatic clearLogs();
      wr_cnt    = 0;
      order_err = 0;
      rd_cnt    = 0;
      for (int w = 0; w < NWORD; w++) wr_log[w] = 16'hDEAD;
   endtask

   task automatic pulseStart();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic waitDone(output int cycles, output bit timed_out);
      cycles    = 0;
      timed_out = 1'b1;
      while (cycles < 20000) begin
         @(posedge clk);
         #1;
         cycles++;
         if (done === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic checkScan(input vec_t v, input bit timed_out);
      int nbad;
      nbad = 0;
      for (int w = 0; w < NWORD; w++)
         if (wr_log[w] !== gold_words[w]) nbad++;
      checkOutput("timeout",     int'(timed_out), 0);
      checkOutput("done",        int'(done), 1);
      checkOutput("busy_end",    int'(busy), 0);
      checkOutput("pix_cnt",     int'(pix_cnt), v.exp_cnt);
      checkOutput("max_dist",    int'(max_dist), v.exp_max);
      checkOutput("write_count", wr_cnt, NWORD);
      checkOutput("write_order", order_err, 0);
      checkOutput("word",        int'(wr_log[v.word_addr]), v.word_val);
      checkOutput("map_words",   nbad, 0);
      checkOutput("read_count",  rd_cnt, gold_reads);
   endtask

   task automatic applyStimulus(input vec_t v, output int cycles);
      bit to;
      loadMap(v.scen);
      computeGold();
      clearLogs();
      pulseStart();
      waitDone(cycles, to);
      checkScan(v, to);
   endtask

   initial begin
      int cyc;
      bit to;

      reset = 1'b0;
      start = 1'b0;

      vecs[0] = '{scen: 0, exp_cnt: 0, exp_max: 0,   word_addr: 10, word_val: 16'h0000};
      vecs[1] = '{scen: 1, exp_cnt: 1, exp_max: 1,   word_addr: 33, word_val: 16'h8000};
`ifdef DT_SKEL_8N_EN
      vecs[2] = '{scen: 2, exp_cnt: 1, exp_max: 2,   word_addr: 21, word_val: 16'h0000};
      vecs[4] = '{scen: 4, exp_cnt: 10, exp_max: 5,  word_addr: 10, word_val: 16'h0D40};
`else
      vecs[2] = '{scen: 2, exp_cnt: 5, exp_max: 2,   word_addr: 21, word_val: 16'h0A00};
      vecs[4] = '{scen: 4, exp_cnt: 14, exp_max: 5,  word_addr: 10, word_val: 16'h0D40};
`endif
      vecs[3] = '{scen: 3, exp_cnt: 1, exp_max: 255, word_addr: 1,  word_val: 16'h0001};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy",     int'(busy), 0);
      checkOutput("rst_done",     int'(done), 0);
      checkOutput("rst_skl_wr",   int'(skl_wr), 0);
      checkOutput("rst_res_rd",   int'(res_rd), 0);
      checkOutput("rst_res_addr", int'(res_addr), 0);
      checkOutput("rst_skl_do",   int'(skl_do), 0);
      checkOutput("rst_max_dist", int'(max_dist), 0);
      checkOutput("rst_pix_cnt",  int'(pix_cnt), 0);
      #2 reset = 1'b1;

      for (int i = 0; i < 5; i++) begin
         $display("[TB] scan scenario %0d", vecs[i].scen);
         applyStimulus(vecs[i], cyc);
         if (vecs[i].scen == 0) checkOutput("zero_map_cycles", cyc, 3*NPIX + 1);
      end

      // Restart while done clears the results; a second start mid-scan is ignored.
      $display("[TB] restart while done, then start while busy");
      loadMap(2);
      computeGold();
      clearLogs();
      pulseStart();
      checkOutput("restart_done",     int'(done), 0);
      checkOutput("restart_busy",     int'(busy), 1);
      checkOutput("restart_max_dist", int'(max_dist), 0);
      checkOutput("restart_pix_cnt",  int'(pix_cnt), 0);
      repeat (400) @(posedge clk);
      pulseStart();
      waitDone(cyc, to);
      checkScan(vecs[2], to);

      // Asynchronous reset in mid-scan, then a fresh full scan.
      $display("[TB] reset in mid-scan");
      loadMap(3);
      computeGold();
      clearLogs();
      pulseStart();
      repeat (300) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checkOutput("midrst_busy",     int'(busy), 0);
      checkOutput("midrst_done",     int'(done), 0);
      checkOutput("midrst_res_rd",   int'(res_rd), 0);
      checkOutput("midrst_res_addr", int'(res_addr), 0);
      checkOutput("midrst_skl_wr",   int'(skl_wr), 0);
      checkOutput("midrst_skl_addr", int'(skl_addr), 0);
      checkOutput("midrst_max_dist", int'(max_dist), 0);
      checkOutput("midrst_pix_cnt",  int'(pix_cnt), 0);
      @(posedge clk);
      #2 reset = 1'b1;
      clearLogs();
      pulseStart();
      waitDone(cyc, to);
      checkScan(vecs[3], to);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
